cv32e40p_rf_wb_arbiter: RTL and testbench
=========================================

# cv32e40p_rf_wb_arbiter

Write-back arbiter for the register file: collects write requests from up to NUM_REQ execution units (ALU, multiplier, LSU, APU) over valid/ready handshakes. Each cycle it grants at most two of them onto write ports A and B, including 64-bit pair writes (rd, rd+1) through port B with instr64. Sits between the EX/WB stage units and the register file, and drives its write ports through one register stage.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 5, register address width (6 when FP registers are separate)
- DATA_WIDTH, 32, data width
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- wb_stall_i  in  1  blocks all grants this cycle
- req_valid_i  in  NUM_REQ  write request per requester
- req_ready_o  out  NUM_REQ  grant; handshake completes when valid & ready
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  destination register
- req_wdata_i  in  NUM_REQ x DATA_WIDTH  data for addr
- req_wdata_hi_i  in  NUM_REQ x DATA_WIDTH  data for addr+1 (pair only)
- req_pair_i  in  NUM_REQ  64-bit pair write
- we_a_o, waddr_a_o, wdata_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH  port A
- we_b_o, waddr_b_o, wdata_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH  port B
- wdata_b1_o  out  DATA_WIDTH  port B upper word
- instr64_oe_o  out  1  port B write is a pair
- protocol_err_o  out  1  one-cycle pulse: illegal request dropped

## Operation

- State: round-robin pointer rr_q (0..NUM_REQ-1), registered port outputs, protocol_err_o.
- Scan order: requesters rr_q, rr_q+1, …, wrapping mod NUM_REQ.
- Port B: first valid requester in scan order (single or pair).
- Port A: next valid requester in scan order after the B winner, provided it is single and its address differs from B's addr (and from B's addr+1 if B is a pair). If that requester fails, port A is left idle; scanning does not continue past it, so requesters are not reordered.
- Two valid requests to the same register: only the earlier one in scan order is granted; the other waits.
- Illegal requests: a pair with odd addr, or with addr+1 beyond the register range. Such a request is granted, not written, and pulses protocol_err_o next cycle. It occupies the B slot.
- Write to address 0 (single, not pair): granted, and the corresponding we_*_o stays 0. This is not an error.
- Pointer update: if any grant was made, rr_q becomes (last granted index + 1) mod NUM_REQ. Otherwise it holds.
- wb_stall_i=1: req_ready_o=0, we_a_o=we_b_o=0 next cycle, rr_q holds.
- Requester rules: once valid is asserted, hold addr, data and pair stable until ready. Valid must not be retracted.

## Timing

- req_ready_o is combinational from valid, addr, pair, rr_q and stall. It must not depend on ready.
- A handshake in cycle N drives we/addr/data/instr64 on the granted port in cycle N+1, for exactly one cycle.
- Ports are idle (we=0) in any cycle after a cycle without a grant on that port.
- Data outputs hold their last value when we=0. Only the we signals and instr64_oe_o are forced to 0.
- Throughput: 2 single writes per cycle; 1 pair plus 1 single per cycle.
- Reset (rst_n=0 at a rising edge): rr_q=0, all we/instr64/err outputs 0, all addr/data outputs 0. req_ready_o=0 while rst_n=0.
- Reset mid-operation: handshakes in the reset cycle do not complete, and no write issues in the next cycle.

## Test plan

- Reset, then all idle: every output 0 and req_ready_o=0000 for 10 cycles.
- Requesters 0 and 1 valid, addr 3/7, data 0xA/0xB, rr_q=0: ready=0011. Next cycle we_b_o=1 with addr 3 / 0xA and we_a_o=1 with addr 7 / 0xB. rr_q becomes 2.
- Requester 2 pair at addr 4 (0x11/0x22) and requester 3 single at addr 5, rr_q=2: only 2 is granted. Next cycle instr64_oe_o=1, waddr_b_o=4, wdata_b1_o=0x22, we_a_o=0. Requester 3 is granted the cycle after.
- All four requesters valid continuously, no conflicts, 8 cycles: each requester is granted exactly 4 times, in grant-pair order {0,1},{2,3},{0,1}…
- Pair at addr 5: granted, we_b_o stays 0, and protocol_err_o=1 for one cycle. A single write to addr 0: granted, no we, no error.
- wb_stall_i held high for 3 cycles with 2 requests pending: ready=0 throughout and rr_q unchanged. Both requests are granted in the first cycle after the stall is released.

Source files
------------

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register-file write-back arbiter: grants up to two requesters per cycle onto
// write ports A and B (B also carries 64-bit pair writes), with registered outputs.
module cv32e40p_rf_wb_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wb_stall_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_hi_i,
    input  logic [NUM_REQ-1:0]                   req_pair_i,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_b_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b1_o,
    output logic                                 instr64_oe_o,
    output logic                                 protocol_err_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [PTR_W-1:0]      b_idx, a_idx, last_idx;
    logic                  b_found, a_seen;
    logic                  b_pair, b_illegal, a_ok;
    logic                  grant_b, grant_a, b_write, a_write;
    logic [ADDR_WIDTH-1:0] b_addr, a_addr;
    logic [ADDR_WIDTH:0]   b_addr_p1;

    // B takes the first valid requester from rr_q; A may only take the very next one.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        b_found = 1'b0;
        a_seen  = 1'b0;
        b_idx   = '0;
        a_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (req_valid_i[idx]) begin
                if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = PTR_W'(idx);
                end else if (!a_seen) begin
                    a_seen = 1'b1;
                    a_idx  = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        b_addr    = req_addr_i[b_idx];
        b_pair    = req_pair_i[b_idx];
        a_addr    = req_addr_i[a_idx];
        b_addr_p1 = {1'b0, b_addr} + (ADDR_WIDTH+1)'(1);
        // A pair must start on an even register and its upper half must exist.
        b_illegal = b_pair & (b_addr[0] | b_addr_p1[ADDR_WIDTH]);
        a_ok      = a_seen & ~req_pair_i[a_idx] & (a_addr != b_addr)
                  & ~(b_pair & ({1'b0, a_addr} == b_addr_p1));
        grant_b   = rst_n & ~wb_stall_i & b_found;
        grant_a   = grant_b & a_ok;
        b_write   = grant_b & ~b_illegal & (b_pair | (b_addr != '0));
        a_write   = grant_a & (a_addr != '0);
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_b) req_ready_o[b_idx] = 1'b1;
        if (grant_a) req_ready_o[a_idx] = 1'b1;
    end

    always_comb begin
        last_idx = grant_a ? a_idx : b_idx;
        rr_d     = rr_q;
        if (grant_b) begin
            rr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q           <= '0;
            we_a_o         <= 1'b0;
            waddr_a_o      <= '0;
            wdata_a_o      <= '0;
            we_b_o         <= 1'b0;
            waddr_b_o      <= '0;
            wdata_b_o      <= '0;
            wdata_b1_o     <= '0;
            instr64_oe_o   <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            rr_q           <= rr_d;
            we_a_o         <= a_write;
            we_b_o         <= b_write;
            instr64_oe_o   <= b_write & b_pair;
            protocol_err_o <= grant_b & b_illegal;
            // Address/data only move on an actual write so idle ports hold their last value.
            if (a_write) begin
                waddr_a_o <= a_addr;
                wdata_a_o <= req_wdata_i[a_idx];
            end
            if (b_write) begin
                waddr_b_o  <= b_addr;
                wdata_b_o  <= req_wdata_i[b_idx];
                wdata_b1_o <= req_wdata_hi_i[b_idx];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Bench for cv32e40p_rf_wb_arbiter: directed scenarios followed by random traffic,
// all compared against a scan-list reference model of the arbitration rules.
module tb_cv32e40p_rf_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stall = 1'b0;
    logic [N-1:0]         valid = '0;
    logic [N-1:0]         pair  = '0;
    logic [N-1:0]         ready;
    logic [N-1:0][AW-1:0] addr     = '0;
    logic [N-1:0][DW-1:0] wdata    = '0;
    logic [N-1:0][DW-1:0] wdata_hi = '0;
    logic                 we_a, we_b, i64, perr;
    logic [AW-1:0]        waddr_a, waddr_b;
    logic [DW-1:0]        wdata_a, wdata_b, wdata_b1;

    cv32e40p_rf_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_stall_i     (stall),
        .req_valid_i    (valid),
        .req_ready_o    (ready),
        .req_addr_i     (addr),
        .req_wdata_i    (wdata),
        .req_wdata_hi_i (wdata_hi),
        .req_pair_i     (pair),
        .we_a_o         (we_a),
        .waddr_a_o      (waddr_a),
        .wdata_a_o      (wdata_a),
        .we_b_o         (we_b),
        .waddr_b_o      (waddr_b),
        .wdata_b_o      (wdata_b),
        .wdata_b1_o     (wdata_b1),
        .instr64_oe_o   (i64),
        .protocol_err_o (perr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_rr = 0;
    logic          m_we_a = 0, m_we_b = 0, m_i64 = 0, m_err = 0;
    logic [AW-1:0] m_waddr_a = '0, m_waddr_b = '0;
    logic [DW-1:0] m_wdata_a = '0, m_wdata_b = '0, m_wdata_b1 = '0;
    int            gcount[N];
    logic [N-1:0]  last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit illegal_pair(input int j);
        int a;
        a = int'(addr[j]);
        return pair[j] && ((a % 2) == 1 || a + 1 > (1 << AW) - 1);
    endfunction

    // Build the list of valid requesters in scan order; B is its head, A its second entry.
    task automatic predict(output int b, output int a);
        int order[$];
        int c;
        b = -1;
        a = -1;
        if (!rst_n || stall) return;
        for (int i = 0; i < N; i++) begin
            if (valid[(m_rr + i) % N]) order.push_back((m_rr + i) % N);
        end
        if (order.size() == 0) return;
        b = order[0];
        if (order.size() > 1) begin
            c = order[1];
            if (!pair[c] && addr[c] != addr[b]
                && !(pair[b] && int'(addr[c]) == int'(addr[b]) + 1)) a = c;
        end
    endtask

    task automatic cycle();
        int b, a;
        logic [N-1:0] er;
        @(negedge clk);
        predict(b, a);
        er = '0;
        if (b >= 0) er[b] = 1'b1;
        if (a >= 0) er[a] = 1'b1;
        last_ready = ready;
        check("ready", 64'(ready), 64'(er));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_rr = 0;
            m_we_a = 0; m_we_b = 0; m_i64 = 0; m_err = 0;
            m_waddr_a = '0; m_waddr_b = '0;
            m_wdata_a = '0; m_wdata_b = '0; m_wdata_b1 = '0;
        end else begin
            m_we_b = b >= 0 && !illegal_pair(b) && (pair[b] || addr[b] != 0);
            m_i64  = m_we_b && pair[b];
            m_err  = b >= 0 && illegal_pair(b);
            if (m_we_b) begin
                m_waddr_b = addr[b];
                m_wdata_b = wdata[b];
                if (pair[b]) m_wdata_b1 = wdata_hi[b];
            end
            m_we_a = a >= 0 && addr[a] != 0;
            if (m_we_a) begin
                m_waddr_a = addr[a];
                m_wdata_a = wdata[a];
            end
            if (b >= 0) m_rr = ((a >= 0 ? a : b) + 1) % N;
        end
        check("we_a", 64'(we_a), 64'(m_we_a));
        check("we_b", 64'(we_b), 64'(m_we_b));
        check("instr64", 64'(i64), 64'(m_i64));
        check("protocol_err", 64'(perr), 64'(m_err));
        check("waddr_a", 64'(waddr_a), 64'(m_waddr_a));
        check("wdata_a", 64'(wdata_a), 64'(m_wdata_a));
        check("waddr_b", 64'(waddr_b), 64'(m_waddr_b));
        check("wdata_b", 64'(wdata_b), 64'(m_wdata_b));
        if (m_i64) check("wdata_b1", 64'(wdata_b1), 64'(m_wdata_b1));
        if (b >= 0) begin valid[b] = 1'b0; gcount[b]++; end
        if (a >= 0) begin valid[a] = 1'b0; gcount[a]++; end
    endtask

    task automatic set_req(input int j, input int ad, input logic pr,
                           input logic [DW-1:0] d, input logic [DW-1:0] dh);
        valid[j]    = 1'b1;
        addr[j]     = AW'(ad);
        pair[j]     = pr;
        wdata[j]    = d;
        wdata_hi[j] = dh;
    endtask

    initial begin
        // Reset, then idle
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Two singles from rr=0
        set_req(0, 3, 1'b0, 32'hA, 32'h0);
        set_req(1, 7, 1'b0, 32'hB, 32'h0);
        cycle();
        check("dual_ready", 64'(last_ready), 64'(4'b0011));
        check("dual_waddr_b", 64'(waddr_b), 64'd3);
        check("dual_wdata_a", 64'(wdata_a), 64'hB);

        // Pair at 4 blocks single at 5 this cycle
        set_req(2, 4, 1'b1, 32'h11, 32'h22);
        set_req(3, 5, 1'b0, 32'h33, 32'h0);
        cycle();
        check("pair_ready", 64'(last_ready), 64'(4'b0100));
        check("pair_i64", 64'(i64), 64'd1);
        check("pair_b1", 64'(wdata_b1), 64'h22);
        check("pair_we_a", 64'(we_a), 64'd0);
        cycle();
        check("after_pair_ready", 64'(last_ready), 64'(4'b1000));

        // All four continuously valid
        for (int j = 0; j < N; j++) gcount[j] = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) set_req(j, 8 + j, 1'b0, $urandom, 32'h0);
            cycle();
            check("rr_order", 64'(last_ready), (i % 2 == 1) ? 64'(4'b1100) : 64'(4'b0011));
        end
        for (int j = 0; j < N; j++) check("fair_count", 64'(gcount[j]), 64'd4);

        // Illegal pair, then a write to x0
        set_req(0, 5, 1'b1, 32'h55, 32'h66);
        cycle();
        check("illegal_err", 64'(perr), 64'd1);
        check("illegal_we_b", 64'(we_b), 64'd0);
        set_req(1, 0, 1'b0, 32'h77, 32'h0);
        cycle();
        check("x0_err", 64'(perr), 64'd0);
        check("x0_we_b", 64'(we_b), 64'd0);

        // Stall for three cycles with two pending requests
        set_req(2, 12, 1'b0, 32'hC, 32'h0);
        set_req(3, 13, 1'b0, 32'hD, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", 64'(last_ready), 64'd0);
        end
        stall = 1'b0;
        cycle();
        check("unstall_ready", 64'(last_ready), 64'(4'b1100));

        // Random traffic with occasional stall and reset
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid[j] && $urandom_range(0, 9) < 6) begin
                    set_req(j, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                           : $urandom_range(0, 31),
                            $urandom_range(0, 3) == 0, $urandom, $urandom);
                end
            end
            stall = $urandom_range(0, 9) == 0;
            rst_n = $urandom_range(0, 99) != 0;
            cycle();
        end
        rst_n = 1'b1;
        stall = 1'b0;
        valid = '0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
